// File: rtl/cpu_ram_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ram_ctrl
// Data-memory controller downstream of top_cpu. It accepts one request per
// en_ram_in strobe while idle, inserts WAIT_CYCLES wait states, then performs
// a single access to an internal single-port RAM. Completion is signalled with
// a one-cycle ready_out pulse. Requests that arrive while busy are dropped.
//
// Optional feature: define CPU_RAM_CLEAR_EN to add a CLEAR state after reset
// that zeroes every RAM word, one per cycle, before the block goes idle.
//
// Parameters:
//   DATA_W      word width
//   ADDR_W      address width (depth = 2**ADDR_W)
//   WAIT_CYCLES wait states before the array access (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en_ram_in  request strobe
//   we_in      1 = write, 0 = read (qualified by en_ram_in)
//   addr_in    word address
//   data_in    write data
//   data_out   registered read data, holds the last read value
//   ready_out  one-cycle completion pulse (reads and writes)
//   busy       high while the controller is not idle
// ---------------------------------------------------------------------------
module cpu_ram_ctrl #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_ram_in,
   input  logic              we_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              ready_out,
   output logic              busy
);

`ifdef CPU_RAM_CLEAR_EN
   typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;
   localparam state_t RST_STATE = ST_CLEAR;
   localparam logic   BUSY_RST  = 1'b1;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   BUSY_RST  = 1'b0;
`endif

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              accept;

   // request captured at the accepting edge; live inputs are ignored after it
   logic [ADDR_W-1:0] addr_r;
   logic              we_r;
   logic [DATA_W-1:0] data_r;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

`ifdef CPU_RAM_CLEAR_EN
   logic [ADDR_W-1:0] clr_addr;
`endif

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      case (state)
`ifdef CPU_RAM_CLEAR_EN
         // the edge that writes the last word also leaves CLEAR
         ST_CLEAR:  if (&clr_addr) state_nxt = ST_IDLE;
`endif
         ST_IDLE: begin
            if (en_ram_in) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ST_ACCESS;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = RST_STATE;
      endcase
   end

   // ---------------------------------------------------------------- RAM port
   // rst suppresses any write on its edge, so a write whose access edge meets
   // reset is discarded.
   always_comb begin
      mem_we    = (state == ST_ACCESS) && we_r && !rst;
      mem_waddr = addr_r;
      mem_wdata = data_r;
`ifdef CPU_RAM_CLEAR_EN
      if (state == ST_CLEAR) begin
         mem_we    = !rst;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end
`endif
   end

   // array has no reset: contents survive rst unless the clear feature runs
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // ---------------------------------------------------------------- control
   // ready_out and busy are registered from the current state, so they trail
   // the state register by one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_STATE;
         cnt       <= 4'd0;
         data_out  <= '0;
         ready_out <= 1'b0;
         busy      <= BUSY_RST;
         addr_r    <= '0;
         we_r      <= 1'b0;
         data_r    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ready_out <= (state == ST_DONE);
         busy      <= (state != ST_IDLE);
         if (accept) begin
            addr_r <= addr_in;
            we_r   <= we_in;
            data_r <= data_in;
         end
         if (state == ST_ACCESS && !we_r) data_out <= mem[addr_r];
      end
   end

`ifdef CPU_RAM_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst)                    clr_addr <= '0;
      else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
   end
`endif

endmodule

// File: tb/tb_cpu_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ram_ctrl
// Directed bench for cpu_ram_ctrl. A second instance built with
// WAIT_CYCLES=0 shares all inputs and is only checked in its own section.
// ---------------------------------------------------------------------------
module tb_cpu_ram_ctrl;

`ifdef CPU_RAM_CLEAR_EN
   localparam logic BUSY_RST = 1'b1;
`else
   localparam logic BUSY_RST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        we;
   logic [7:0]  addr;
   logic [15:0] din;
   logic [15:0] dout, dout0;
   logic        ready, ready0;
   logic        busy, busy0;

   int checks = 0;
   int errors = 0;

   int          lat, lat0, npulse;
   logic [15:0] rd, rd0, prev_dout;
   logic [15:0] rv, bv;

   always #5 clk = ~clk;

   cpu_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .en_ram_in(en), .we_in(we), .addr_in(addr),
      .data_in(din), .data_out(dout), .ready_out(ready), .busy(busy)
   );

   cpu_ram_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .en_ram_in(en), .we_in(we), .addr_in(addr),
      .data_in(din), .data_out(dout0), .ready_out(ready0), .busy(busy0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one request; latency counted in edges after the accepting edge
   task automatic do_req(input logic w, input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      en = 1'b1; we = w; addr = a; din = d;
      prev_dout = dout;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0; we = ~w; addr = ~a; din = ~d;
      lat = -1; lat0 = -1; npulse = 0; rd = '0; rd0 = '0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready) begin
            npulse++;
            if (lat < 0) begin lat = k; rd = dout; end
         end
         if (ready0 && lat0 < 0) begin lat0 = k; rd0 = dout0; end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || busy0) && n < 600) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (n >= 600) chk("idle_timeout", 32'(n), 32'd0);
   endtask

   task automatic count_pulses(input int cycles);
      npulse = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready) npulse++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dout",  32'(dout),  32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy",  32'(busy),  32'(BUSY_RST));
      rst = 1'b0;

`ifdef CPU_RAM_CLEAR_EN
      begin
         int n;
         n = 0;
         while (busy && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
         end
         // busy stays high through the 256th edge after release
         chk("clr_len", 32'(n), 32'd257);
      end
      wait_idle();
      do_req(1'b0, 8'hFF, 16'h0);
      chk("clr_rd_ff", 32'(rd), 32'd0);
`endif

      // write then read
      do_req(1'b1, 8'h3A, 16'hBEEF);
      chk("wr_lat",    32'(lat),    32'd4);
      chk("wr_pulses", 32'(npulse), 32'd1);
      chk("wr_dout",   32'(rd),     32'(prev_dout));
      do_req(1'b0, 8'h3A, 16'h0);
      chk("rd_lat",    32'(lat),    32'd4);
      chk("rd_data",   32'(rd),     32'hBEEF);
      chk("rd_hold",   32'(dout),   32'hBEEF);

      // known contents for later scenarios
      do_req(1'b1, 8'h11, 16'h5555);
      do_req(1'b1, 8'h05, 16'h1111);
      do_req(1'b1, 8'h06, 16'h2222);

      // request during WAIT is dropped
      @(negedge clk);
      en = 1'b1; we = 1'b0; addr = 8'h10; din = '0;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      en = 1'b1; we = 1'b1; addr = 8'h11; din = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      count_pulses(12);
      chk("drop_pulses", 32'(npulse), 32'd1);
      wait_idle();
      do_req(1'b0, 8'h11, 16'h0);
      chk("drop_rd11", 32'(rd), 32'h5555);

      // reset one edge after accepting a write
      @(negedge clk);
      en = 1'b1; we = 1'b1; addr = 8'h05; din = 16'hAAAA;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_busy", 32'(busy), 32'(BUSY_RST));
      count_pulses(10);
      chk("midrst_pulses", 32'(npulse), 32'd0);
      wait_idle();
      do_req(1'b0, 8'h05, 16'h0);
`ifdef CPU_RAM_CLEAR_EN
      chk("midrst_rd05", 32'(rd), 32'h0000);
`else
      chk("midrst_rd05", 32'(rd), 32'h1111);
`endif

      // reset on the ACCESS edge of a write discards the write
      @(negedge clk);
      en = 1'b1; we = 1'b1; addr = 8'h06; din = 16'hDEAD;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_idle();
      do_req(1'b0, 8'h06, 16'h0);
`ifdef CPU_RAM_CLEAR_EN
      chk("accrst_rd06", 32'(rd), 32'h0000);
`else
      chk("accrst_rd06", 32'(rd), 32'h2222);
`endif

      // simultaneous rst and request: request dropped
      @(negedge clk);
      rst = 1'b1; en = 1'b1; we = 1'b0; addr = 8'h3A;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      count_pulses(8);
      chk("rstreq_pulses", 32'(npulse), 32'd0);
      wait_idle();

      // back-to-back reads with en held: accepts every 5 edges
      @(negedge clk);
      en = 1'b1; we = 1'b0; addr = 8'h00;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         @(negedge clk);
         rv[i] = ready;
         bv[i] = busy;
      end
      en = 1'b0;
      chk("b2b_ready", 32'(rv), 32'h4210);
      chk("b2b_busy",  32'(bv), 32'h7BDE);
      repeat (8) @(posedge clk);
      wait_idle();

      // zero-wait-state instance
      do_req(1'b1, 8'h7F, 16'h0F0F);
      chk("w0_wr_lat", 32'(lat0), 32'd2);
      do_req(1'b0, 8'h7F, 16'h0);
      chk("w0_rd_lat",  32'(lat0), 32'd2);
      chk("w0_rd_data", 32'(rd0),  32'h0F0F);
      chk("w2_rd7f",    32'(rd),   32'h0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
